// File: rtl/magnitude_comp_pkg.sv
// Shared result encoding and flag mapping for the magnitude comparator.
package magnitude_comp_pkg;

    typedef logic [1:0] cmp_res_t;

    localparam cmp_res_t CMP_EQ = 2'b00;
    localparam cmp_res_t CMP_GT = 2'b01;
    localparam cmp_res_t CMP_LT = 2'b10;

    // Returns {g, l, e}; the unused code 2'b11 maps to no flag.
    function automatic logic [2:0] res_to_flags(input cmp_res_t res);
        logic [2:0] flags;
        flags = 3'b000;
        case (res)
            CMP_GT:  flags = 3'b100;
            CMP_LT:  flags = 3'b010;
            CMP_EQ:  flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/magnitude_comp_slice.sv
// One bit of the ripple comparator: an upstream (higher-bit) decision wins,
// otherwise this bit decides if a_i and b_i differ.
module magnitude_comp_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic gt_in,
    input  logic lt_in,
    output logic gt_out,
    output logic lt_out
);

    logic undecided;

    assign undecided = ~gt_in & ~lt_in;
    assign gt_out    = gt_in | (undecided & a_i & ~b_i);
    assign lt_out    = lt_in | (undecided & ~a_i & b_i);

endmodule

// File: rtl/magnitude_comp.sv
// Registered magnitude comparator with one-hot g/l/e flags, one cycle latency.
// Define MAGNITUDE_COMP_SIGNED_EN to treat a and b as two's-complement.
module magnitude_comp
    import magnitude_comp_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             g,
    output logic             l,
    output logic             e
);

    logic [WIDTH:0] gt_c;
    logic [WIDTH:0] lt_c;
    cmp_res_t       res;
    logic [2:0]     flags;

    assign gt_c[WIDTH] = 1'b0;
    assign lt_c[WIDTH] = 1'b0;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        logic a_bit;
        logic b_bit;
`ifdef MAGNITUDE_COMP_SIGNED_EN
        // A set sign bit means negative, so the MSB decision is inverted.
        if (i == WIDTH - 1) begin : g_sign
            assign a_bit = b[i];
            assign b_bit = a[i];
        end else begin : g_mag
            assign a_bit = a[i];
            assign b_bit = b[i];
        end
`else
        assign a_bit = a[i];
        assign b_bit = b[i];
`endif
        magnitude_comp_slice u_slice (
            .a_i    (a_bit),
            .b_i    (b_bit),
            .gt_in  (gt_c[i+1]),
            .lt_in  (lt_c[i+1]),
            .gt_out (gt_c[i]),
            .lt_out (lt_c[i])
        );
    end

    always_comb begin
        res = CMP_EQ;
        if (gt_c[0]) begin
            res = CMP_GT;
        end else if (lt_c[0]) begin
            res = CMP_LT;
        end
    end

    assign flags = res_to_flags(res);

    // Flags hold their last result when in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            g         <= 1'b0;
            l         <= 1'b0;
            e         <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                {g, l, e} <= flags;
            end
        end
    end

endmodule

// File: tb/tb_magnitude_comp.sv
// Scoreboard bench for magnitude_comp (WIDTH=2); expectations follow
// MAGNITUDE_COMP_SIGNED_EN when it is defined.
module tb_magnitude_comp;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    // Hand-computed {g,l,e}, indexed by a*4+b.
`ifdef MAGNITUDE_COMP_SIGNED_EN
    localparam logic [2:0] EXP_TBL [16] = '{
        EQ, LT, GT, GT,
        GT, EQ, GT, GT,
        LT, LT, EQ, LT,
        LT, LT, GT, EQ};
`else
    localparam logic [2:0] EXP_TBL [16] = '{
        EQ, LT, LT, LT,
        GT, EQ, LT, LT,
        GT, GT, EQ, LT,
        GT, GT, GT, EQ};
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b1;
    logic [1:0] a = 2'b11;
    logic [1:0] b = 2'b00;
    logic       out_valid, g, l, e;

    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] exp_q[$];
    logic [2:0] last_exp = 3'b000;

    magnitude_comp #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .g         (g),
        .l         (l),
        .e         (e)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got {v,g,l,e}=%b, expected %b", name, act, req);
        end
    endtask

    task automatic send(input logic [1:0] av, input logic [1:0] bv, input logic [2:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        exp_q.push_back(exp);
        last_exp = exp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Monitor: out_valid must track pending results, and each result must match.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", {3'b000, out_valid}, {3'b000, exp_q.size() != 0});
            if (out_valid && exp_q.size() != 0) begin
                check("result", {out_valid, g, l, e}, {1'b1, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 check("reset_async", {out_valid, g, l, e}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", {out_valid, g, l, e}, 4'b0000);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 16; i++) begin
            send(i[3:2], i[1:0], EXP_TBL[i]);
        end
        idle(2);

        // Hold: flags keep the last result while in_valid is low.
        send(2'b10, 2'b01, EXP_TBL[9]);
        @(negedge clk);
        in_valid = 1'b0;
        a = 2'b00;
        b = 2'b11;
        repeat (2) @(negedge clk);
        check("hold", {out_valid, g, l, e}, {1'b0, last_exp});

        send(2'b00, 2'b00, EXP_TBL[0]);
        send(2'b00, 2'b01, EXP_TBL[1]);
        send(2'b01, 2'b00, EXP_TBL[4]);
        idle(2);

        // Reset between clocks discards the just-registered result.
        send(2'b11, 2'b00, EXP_TBL[12]);
        #1 check("pre_reset", {out_valid, g, l, e}, {1'b1, EXP_TBL[12]});
        #1 rst_n = 1'b0;
        exp_q.delete();
        in_valid = 1'b0;
        #1 check("reset_mid", {out_valid, g, l, e}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b01, 2'b01, EXP_TBL[5]);
        idle(3);

`ifdef MAGNITUDE_COMP_SIGNED_EN
        send(2'b10, 2'b01, LT);
        send(2'b01, 2'b11, GT);
        send(2'b11, 2'b11, EQ);
`else
        send(2'b10, 2'b01, GT);
        send(2'b01, 2'b11, LT);
        send(2'b11, 2'b11, EQ);
`endif
        idle(3);

        check("drained", {1'b0, 3'(exp_q.size())}, 4'b0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/magnitude_comp.md
Name: magnitude_comp

Overview:
- Registered unsigned magnitude comparator for two WIDTH-bit operands a and b.
- Produces one-hot greater/less/equal flags one clock after a qualified input sample.
- Used as a small datapath utility wherever a registered ordering decision on two operands is needed.
- Default WIDTH=2 covers the 2-bit operand pairs used in unit-level checks.

Parameters:
- WIDTH, 2, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a and b on the current clock edge.
- a  input  WIDTH  operand A, unsigned by default.
- b  input  WIDTH  operand B, unsigned by default.
- out_valid  output  1  high for one cycle when g/l/e carry a new result.
- g  output  1  a > b.
- l  output  1  a < b.
- e  output  1  a == b.

Behaviour:
- Reset: asserting rst_n low immediately forces g=0, l=0, e=0 and out_valid=0, independent of clk.
- Reset release is sampled on the next rising clk edge; the first edge with rst_n high behaves as a normal cycle.
- Sampling: on a rising clk edge with in_valid=1:
  - register the comparison of a and b into g/l/e;
  - set out_valid=1.
- Hold: on an edge with in_valid=0:
  - out_valid=0;
  - g/l/e hold their last value; they are not cleared.
- Latency: exactly 1 cycle from input sample to result. Throughput is one compare per cycle; back-to-back in_valid is allowed.
- Invariant: after the first valid sample, exactly one of g, l, e is 1. Before that they are all 0.
- Arithmetic: compare full WIDTH bits, MSB first. The first differing bit decides; a 1 in a gives g, a 1 in b gives l. No differing bit gives e.
- Boundaries:
  - a=b=0 and a=b=all-ones give e=1.
  - a=all-ones, b=0 gives g=1.
  - a=0, b=all-ones gives l=1.
- No X propagation: inputs are only sampled when in_valid=1.
- Reset mid-stream: a result pending on the same edge as reset assertion is discarded. out_valid stays 0 until the next valid sample after release.

Optional Feature:
- Macro: MAGNITUDE_COMP_SIGNED_EN.
- Defined: a and b are two's-complement. The MSB slice inverts its decision, so a=10 (-2) and b=01 (+1) at WIDTH=2 give l=1.
- Undefined: unsigned compare as described above; a=10, b=01 gives g=1.
- Reset, latency and the one-hot invariant are identical in both builds.

Decomposition:
- Shared package magnitude_comp_pkg:
  - 2-bit result-encoding typedef cmp_res_t with constants CMP_EQ=2'b00, CMP_GT=2'b01, CMP_LT=2'b10;
  - function res_to_flags mapping cmp_res_t to {g,l,e}.
- Sub-module magnitude_comp_slice:
  - combinational 1-bit slice taking a_i, b_i and upstream gt_in/lt_in;
  - produces gt_out/lt_out, implementing "higher bit decides".
- Top level: chain WIDTH slices MSB to LSB with a generate loop, then one register stage for g/l/e/out_valid.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, a=11, b=00 -> g=l=e=0, out_valid=0 throughout, including asynchronously mid-cycle.
- Exhaustive WIDTH=2, unsigned build: all 16 pairs (a,b) from 00/00 to 11/11, one per cycle with in_valid=1:
  - each result appears one cycle later with out_valid=1;
  - e.g. 01/10 -> l=1, 10/01 -> g=1, 11/11 -> e=1;
  - exactly one flag high every time.
- Hold: after a=10, b=01 with g=1, drop in_valid and change a=00, b=11 -> out_valid=0 and g stays 1, l=0, e=0.
- Back-to-back: in_valid=1 for 3 cycles with (00,00), (00,01), (01,00) -> e, l, g on consecutive cycles after 1-cycle latency.
- Reset mid-stream: assert rst_n=0 between clocks right after sampling a=11, b=00 -> g drops to 0 immediately. The next valid sample after release (01,01) gives e=1 one cycle later.
- Signed build (MAGNITUDE_COMP_SIGNED_EN): (10,01) -> l=1; (01,11) -> g=1; (11,11) -> e=1.
